// File: rtl/vga_text_wr_sched.sv
// rtl/vga_text_wr_sched.sv - write-port scheduler for the text character RAM; optional macro VGA_WR_BLANK_ONLY_EN
module vga_text_wr_sched #(
    parameter int                COLS      = 80,
    parameter int                ROWS      = 30,
    parameter int                ADDR_W    = 12,
    parameter int                CHAR_W    = 7,
    parameter logic [CHAR_W-1:0] FILL_CHAR = 7'h20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              video_on,
    input  logic              clr_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CHAR_W-1:0] wr_char,
    output logic              wr_ack,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [CHAR_W-1:0] ram_din,
    output logic              busy,
    output logic              clr_done
);

    localparam logic [ADDR_W:0]   CELLS     = (ADDR_W+1)'(COLS * ROWS);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              win;
    logic              we_d, ack_d, busy_d, done_d;
    logic [ADDR_W-1:0] addr_d;
    logic [CHAR_W-1:0] din_d;

`ifdef VGA_WR_BLANK_ONLY_EN
    assign win = ~video_on;
`else
    logic unused_video_on;
    assign unused_video_on = video_on;
    assign win             = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        ack_d   = 1'b0;
        addr_d  = ram_addr;
        din_d   = ram_din;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (wr_req && win && !wr_ack) begin
                    // Blocking on wr_ack forces the idle gap the host needs to drop its request.
                    ack_d = 1'b1;
                    if ({1'b0, wr_addr} < CELLS) begin
                        we_d   = 1'b1;
                        addr_d = wr_addr;
                        din_d  = wr_char;
                    end
                end
            end
            CLEAR: begin
                if (win) begin
                    we_d   = 1'b1;
                    addr_d = cnt_q;
                    din_d  = FILL_CHAR;
                    if (cnt_q == LAST_CELL) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Covers the clear-entry cycle and the cycle carrying the final fill write.
        busy_d = (state_q == CLEAR) || (state_d == CLEAR);
        done_d = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_ack   <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ack   <= ack_d;
            ram_we   <= we_d;
            ram_addr <= addr_d;
            ram_din  <= din_d;
            busy     <= busy_d;
            clr_done <= done_d;
        end
    end

endmodule

// File: tb/tb_vga_text_wr_sched.sv
// tb/tb_vga_text_wr_sched.sv - randomized self-checking bench for vga_text_wr_sched
module tb_vga_text_wr_sched;
    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int ADDR_W = 12;
    localparam int CHAR_W = 7;
    localparam int CELLS  = COLS * ROWS;
    localparam logic [CHAR_W-1:0] FILL = 7'h20;

    logic              clk = 1'b0;
    logic              reset;
    logic              video_on, clr_req, wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [CHAR_W-1:0] wr_char;
    logic              wr_ack, ram_we, busy, clr_done;
    logic [ADDR_W-1:0] ram_addr;
    logic [CHAR_W-1:0] ram_din;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_text_wr_sched dut (
        .clk      (clk),
        .reset    (reset),
        .video_on (video_on),
        .clr_req  (clr_req),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_char  (wr_char),
        .wr_ack   (wr_ack),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .busy     (busy),
        .clr_done (clr_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit win_of(input logic v);
        bit w;
        w = !v;
`ifndef VGA_WR_BLANK_ONLY_EN
        w = 1'b1;
`endif
        return w;
    endfunction

    // One host transaction: the ack (and write, if in range) must follow the first windowed cycle.
    task automatic host_write(input logic [ADDR_W-1:0] a, input logic [CHAR_W-1:0] c);
        bit pred;
        bit done = 0;
        wr_req   = 1'b1;
        wr_addr  = a;
        wr_char  = c;
        video_on = 1'($urandom);
        pred     = win_of(video_on);
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (pred) begin
                check("host_ack", 32'(wr_ack), 32'd1);
                check("host_we", 32'(ram_we), 32'(int'(a) < CELLS));
                if (int'(a) < CELLS) begin
                    check("host_addr", 32'(ram_addr), 32'(a));
                    check("host_din", 32'(ram_din), 32'(c));
                end
                done = 1;
            end else begin
                check("stall_quiet", 32'({wr_ack, ram_we}), 32'd0);
                video_on = 1'($urandom);
                pred     = win_of(video_on);
            end
        end
        check("host_ack_seen", 32'(done), 32'd1);
        wr_req   = 1'b0;
        video_on = 1'($urandom);
        @(negedge clk);
        check("single_pulse", 32'({wr_ack, ram_we}), 32'd0);
    endtask

    // Full-screen clear; optionally a host write raised in the same cycle must wait until after clr_done.
    task automatic run_clear(input bit with_host);
        int exp_addr = 0, first = -1, last = -1, done_cyc = -1, ack_cyc = -1;
        int bad_addr = 0, bad_din = 0, bad_busy = 0, early_ack = 0, cyc = 0;
        clr_req = 1'b1;
        if (with_host) begin
            wr_req  = 1'b1;
            wr_addr = 12'd5;
            wr_char = 7'h55;
        end
        video_on = 1'($urandom);
        while (cyc < 20000 && !(done_cyc >= 0 && (!with_host || ack_cyc >= 0))) begin
            @(negedge clk);
            cyc++;
            clr_req = 1'b0;
            if (cyc == 1) check("busy_start", 32'(busy), 32'd1);
            if (done_cyc < 0) begin
                if (wr_ack) early_ack++;
                if (ram_we) begin
                    if (first < 0) first = cyc;
                    last = cyc;
                    if (int'(ram_addr) != exp_addr) bad_addr++;
                    if (ram_din != FILL) bad_din++;
                    if (!busy) bad_busy++;
                    exp_addr++;
                end
                if (clr_done) begin
                    done_cyc = cyc;
                    check("done_after_last", 32'(cyc), 32'(last + 1));
                    check("busy_low_done", 32'(busy), 32'd0);
                end
                // Stray clear requests mid-clear must be ignored; keep them clear of the tail.
                if (exp_addr < CELLS - 10 && $urandom_range(0, 99) == 0) clr_req = 1'b1;
            end else if (wr_ack && ack_cyc < 0) begin
                ack_cyc = cyc;
                check("post_clear_we", 32'(ram_we), 32'd1);
                check("post_clear_addr", 32'(ram_addr), 32'd5);
                check("post_clear_din", 32'(ram_din), 32'h55);
                wr_req = 1'b0;
            end
            video_on = 1'($urandom);
        end
        check("clear_done_seen", 32'(done_cyc >= 0), 32'd1);
        check("clear_count", 32'(exp_addr), 32'(CELLS));
        check("clear_addr_seq", 32'(bad_addr), 32'd0);
        check("clear_fill", 32'(bad_din), 32'd0);
        check("clear_busy", 32'(bad_busy), 32'd0);
        check("clear_no_ack", 32'(early_ack), 32'd0);
`ifndef VGA_WR_BLANK_ONLY_EN
        check("clear_first_cyc", 32'(first), 32'd2);
        check("clear_span", 32'(last - first + 1), 32'(CELLS));
`endif
        if (with_host) begin
            check("host_after_clear", 32'(ack_cyc >= 0), 32'd1);
`ifndef VGA_WR_BLANK_ONLY_EN
            check("host_ack_latency", 32'(ack_cyc), 32'(done_cyc + 1));
`endif
        end
        wr_req  = 1'b0;
        clr_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int guard;
        reset    = 1'b0;
        video_on = 1'b0;
        clr_req  = 1'b0;
        wr_req   = 1'b0;
        wr_addr  = '0;
        wr_char  = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("reset_outs", 32'({wr_ack, ram_we, ram_addr, ram_din, busy, clr_done}), 32'd0);
            {video_on, clr_req, wr_req} = 3'($urandom);
            wr_addr = 12'($urandom);
            wr_char = 7'($urandom);
        end
        {video_on, clr_req, wr_req} = 3'b000;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_after_reset", 32'({wr_ack, ram_we, busy, clr_done}), 32'd0);
        end

        host_write(12'd100, 7'h41);
        host_write(12'd2400, 7'h12);
        host_write(12'd2399, 7'h7f);
        host_write(12'd0, 7'h01);
        host_write(12'd4095, 7'h33);

`ifdef VGA_WR_BLANK_ONLY_EN
        wr_req   = 1'b1;
        wr_addr  = 12'd200;
        wr_char  = 7'h42;
        video_on = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("stall_50", 32'({wr_ack, ram_we}), 32'd0);
        end
        video_on = 1'b0;
        @(negedge clk);
        check("stall_release", 32'({wr_ack, ram_we, ram_addr, ram_din}), 32'({1'b1, 1'b1, 12'd200, 7'h42}));
        wr_req = 1'b0;
        @(negedge clk);
`endif

        for (int i = 0; i < 20; i++) begin
            logic [ADDR_W-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(CELLS, 4095))
                                             : 12'($urandom_range(0, CELLS - 1));
            host_write(a, 7'($urandom));
        end

        run_clear(1'b1);
        run_clear(1'b0);

        // Reset mid-clear after the write to cell 1000.
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        guard   = 0;
        while (!(ram_we && ram_addr == 12'd1000) && guard < 20000) begin
            @(negedge clk);
            video_on = 1'($urandom);
            guard++;
        end
        check("reached_1000", 32'(guard < 20000), 32'd1);
        #2 reset = 1'b0;
        #1 check("abort_outs", 32'({wr_ack, ram_we, ram_addr, ram_din, busy, clr_done}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        guard = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (clr_done || ram_we || busy) guard++;
            video_on = 1'($urandom);
        end
        check("no_done_after_abort", 32'(guard), 32'd0);
        run_clear(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
